// File: rtl/axi_burst_write_master_pkg.sv
// Shared AXI write-path definitions: burst/response codes, master FSM encoding
// and the command legality check used by the master and the matching slave.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // WRAP bursts must span a power-of-two beat count (2, 4, 8 or 16).
    function automatic logic cmd_is_legal(input logic [2:0]  size,
                                          input logic [3:0]  len,
                                          input logic [1:0]  burst,
                                          input int unsigned max_size);
        logic ok;
        ok = (32'(size) <= max_size) && (burst != BURST_RSVD);
        if (burst == BURST_WRAP) begin
            ok = ok && ((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_burst_write_master_if.sv
// AXI3-style write channels (AW, W, B) bundled for master and slave ends.
interface axi_burst_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;

    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;

    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/axi_beat_addr_gen.sv
// Combinational per-beat address stepper and byte-strobe generator for
// FIXED/INCR/WRAP bursts, including unaligned starts and narrow transfers.
module axi_beat_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = 2
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [2:0]          size,
    input  logic [3:0]          len,
    input  logic [1:0]          burst,
    output logic [ADDR_W-1:0]   next_addr,
    output logic [DATA_W/8-1:0] strb
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    logic [2:0]        size_c;
    logic [ADDR_W-1:0] n_bytes;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] wrap_span;
    logic [ADDR_W-1:0] wrap_lo;
    logic [ADDR_W-1:0] wrap_next;
    logic [7:0]        lane_lo;
    logic [7:0]        lane_hi;

    // Oversized beats are rejected upstream; clamping keeps the lane math in range.
    assign size_c    = (32'(size) > MAX_SIZE) ? 3'(MAX_SIZE) : size;
    assign n_bytes   = ADDR_W'(1) << size_c;
    assign aligned   = addr & ~(n_bytes - ADDR_W'(1));
    assign wrap_span = (ADDR_W'(len) + ADDR_W'(1)) << size_c;
    assign wrap_lo   = addr & ~(wrap_span - ADDR_W'(1));

    always_comb begin
        wrap_next = addr + n_bytes;
        if (wrap_next == (wrap_lo + wrap_span)) begin
            wrap_next = wrap_lo;
        end
        case (burst_t'(burst))
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_next;
            default:     next_addr = aligned + n_bytes;
        endcase
    end

    // Active lanes run from the byte address up to the end of the aligned beat.
    assign lane_lo = 8'(addr[OFF_W-1:0]);
    assign lane_hi = 8'(aligned[OFF_W-1:0]) + 8'(n_bytes) - 8'd1;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign strb[gi] = (8'(gi) >= lane_lo) && (8'(gi) <= lane_hi);
        end
    endgenerate

endmodule

// File: rtl/axi_burst_write_master.sv
// Single-outstanding AXI3 write burst master: command in, AW then W beats from
// a local stream through a one-entry output register, B response reported back.
module axi_burst_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_SIZE = 2
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,

    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,

    output logic                done_valid,
    output logic [1:0]          done_resp,

    axi_burst_write_master_if.master axi
);
    localparam int STRB_W = DATA_W / 8;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] aw_addr_reg;
    logic [3:0]        aw_len_reg;
    logic [2:0]        aw_size_reg;
    logic [1:0]        aw_burst_reg;
    logic [ADDR_W-1:0] beat_addr_reg;
    logic [3:0]        beat_cnt_reg;
    logic              last_loaded_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;
    logic              wlast_reg;
    logic              wvalid_reg;
    logic              done_valid_reg;
    logic [1:0]        done_resp_reg;

    logic              cmd_legal;
    logic              cmd_fire;
    logic              w_load;
    logic              w_fire;
    logic              b_fire;
    logic [ADDR_W-1:0] next_addr;
    logic [STRB_W-1:0] beat_strb;

    axi_beat_addr_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_SIZE (MAX_SIZE)
    ) u_addr_gen (
        .addr      (beat_addr_reg),
        .size      (aw_size_reg),
        .len       (aw_len_reg),
        .burst     (aw_burst_reg),
        .next_addr (next_addr),
        .strb      (beat_strb)
    );

    assign cmd_legal = cmd_is_legal(cmd_size, cmd_len, cmd_burst, MAX_SIZE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        axi.AWVALID = 1'b0;
        axi.BREADY  = 1'b0;
        cmd_fire    = 1'b0;
        w_load      = 1'b0;
        w_fire      = 1'b0;
        b_fire      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Hold off new commands during the completion pulse.
                cmd_ready = !done_valid_reg;
                cmd_fire  = cmd_valid && cmd_ready;
                if (cmd_fire && cmd_legal) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                axi.AWVALID = 1'b1;
                if (axi.AWREADY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                wr_ready = !last_loaded_reg && (!wvalid_reg || axi.WREADY);
                w_load   = wr_valid && wr_ready;
                w_fire   = wvalid_reg && axi.WREADY;
                if (w_fire && wlast_reg) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                axi.BREADY = 1'b1;
                b_fire     = axi.BVALID;
                if (b_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_addr_reg     <= '0;
            aw_len_reg      <= '0;
            aw_size_reg     <= '0;
            aw_burst_reg    <= '0;
            beat_addr_reg   <= '0;
            beat_cnt_reg    <= '0;
            last_loaded_reg <= 1'b0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            wlast_reg       <= 1'b0;
            wvalid_reg      <= 1'b0;
            done_valid_reg  <= 1'b0;
            done_resp_reg   <= '0;
        end else begin
            done_valid_reg <= 1'b0;
            if (cmd_fire) begin
                if (cmd_legal) begin
                    aw_addr_reg     <= cmd_addr;
                    aw_len_reg      <= cmd_len;
                    aw_size_reg     <= cmd_size;
                    aw_burst_reg    <= cmd_burst;
                    beat_addr_reg   <= cmd_addr;
                    beat_cnt_reg    <= '0;
                    last_loaded_reg <= 1'b0;
                end else begin
                    done_valid_reg <= 1'b1;
                    done_resp_reg  <= RESP_SLVERR;
                end
            end
            if (w_load) begin
                wdata_reg     <= wr_data;
                wstrb_reg     <= beat_strb;
                wlast_reg     <= (beat_cnt_reg == aw_len_reg);
                wvalid_reg    <= 1'b1;
                beat_addr_reg <= next_addr;
                beat_cnt_reg  <= beat_cnt_reg + 4'd1;
                if (beat_cnt_reg == aw_len_reg) begin
                    last_loaded_reg <= 1'b1;
                end
            end else if (w_fire) begin
                wvalid_reg <= 1'b0;
            end
            if (b_fire) begin
                done_valid_reg <= 1'b1;
                done_resp_reg  <= axi.BRESP;
            end
        end
    end

    assign axi.AWADDR  = aw_addr_reg;
    assign axi.AWLEN   = aw_len_reg;
    assign axi.AWSIZE  = aw_size_reg;
    assign axi.AWBURST = aw_burst_reg;
    assign axi.WDATA   = wdata_reg;
    assign axi.WSTRB   = wstrb_reg;
    assign axi.WLAST   = wlast_reg;
    assign axi.WVALID  = wvalid_reg;
    assign done_valid  = done_valid_reg;
    assign done_resp   = done_resp_reg;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: scripted bursts against a simple
// slave, hand-computed beat strobes/data, illegal commands and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_burst_write_master;
    import axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        done_valid;
    logic [1:0]  done_resp;

    logic [31:0] g_addr = '0;
    logic [2:0]  g_size = '0;
    logic [3:0]  g_len = '0;
    logic [1:0]  g_burst = '0;
    logic [31:0] g_next;
    logic [3:0]  g_strb;

    int total = 0;
    int bad = 0;

    axi_burst_write_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_burst_write_master #(.ADDR_W(32), .DATA_W(32), .MAX_SIZE(2)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .axi        (axi)
    );

    axi_beat_addr_gen #(.ADDR_W(32), .DATA_W(32), .MAX_SIZE(2)) u_gen (
        .addr      (g_addr),
        .size      (g_size),
        .len       (g_len),
        .burst     (g_burst),
        .next_addr (g_next),
        .strb      (g_strb)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic gen_check(input string tag, input logic [31:0] a, input logic [2:0] s,
                             input logic [3:0] l, input logic [1:0] b,
                             input logic [31:0] exp_next, input logic [3:0] exp_strb);
        g_addr = a; g_size = s; g_len = l; g_burst = b;
        #1;
        chk({tag, "_next"}, g_next, exp_next);
        chk({tag, "_strb"}, g_strb, exp_strb);
    endtask

    task automatic send_cmd(input string name, input logic [31:0] a, input logic [3:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        @(negedge ACLK);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    // exp_strb holds beat k's strobe in bits [4k+3:4k]; beat k carries data0+k.
    task automatic run_burst(input string name, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] data0, input logic [63:0] exp_strb,
                             input logic [1:0] bresp, input int aw_delay, input int stall_beat,
                             input logic [15:0] gap_mask, input bit early_b);
        int  n;
        int  beats;
        bit  aw_done;
        bit  wlast_seen;
        n = int'(len) + 1;
        beats = 0; aw_done = 0; wlast_seen = 0;
        send_cmd(name, addr, len, size, burst);
        if (early_b) begin
            axi.BVALID = 1'b1; axi.BRESP = bresp;
        end
        fork
            begin : aw_side
                axi.AWREADY = (aw_delay == 0);
                for (int c = 0; c < 50 && !aw_done; c++) begin
                    @(negedge ACLK);
                    chk({name, "_aw"}, {22'd0, axi.AWVALID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST},
                        {22'd0, 1'b1, addr, len, size, burst});
                    if (axi.AWREADY) aw_done = 1;
                    else begin
                        @(posedge ACLK); #1;
                        if (c + 1 >= aw_delay) axi.AWREADY = 1'b1;
                    end
                end
                if (!aw_done) chk({name, "_aw_timeout"}, 0, 1);
                @(posedge ACLK); #1;
                axi.AWREADY = 1'b0;
            end
            begin : feed_side
                int  k;
                bit  gap_done;
                k = 0; gap_done = 0;
                for (int c = 0; c < 300 && k < n; c++) begin
                    @(posedge ACLK); #1;
                    if (gap_mask[k] && !gap_done) begin
                        wr_valid = 1'b0; gap_done = 1;
                    end else begin
                        wr_valid = 1'b1; wr_data = data0 + k;
                    end
                    @(negedge ACLK);
                    if (wr_valid && wr_ready) begin
                        k++; gap_done = 0;
                    end
                end
                if (k < n) chk({name, "_feed_timeout"}, k, n);
                @(posedge ACLK); #1;
                wr_valid = 1'b0;
            end
            begin : w_side
                int          stall_left;
                bit          prev_stall;
                logic [36:0] prev_pay;
                stall_left = 3; prev_stall = 0; prev_pay = '0;
                for (int c = 0; c < 300 && !wlast_seen; c++) begin
                    @(posedge ACLK); #1;
                    axi.WREADY = !((beats == stall_beat) && (stall_left > 0) && axi.WVALID);
                    if (!axi.WREADY) stall_left--;
                    @(negedge ACLK);
                    if (prev_stall)
                        chk({name, "_w_hold"}, {27'd0, axi.WVALID, axi.WDATA, axi.WSTRB, axi.WLAST},
                            {27'd0, 1'b1, prev_pay});
                    if (axi.WVALID && !aw_done) chk({name, "_w_before_aw"}, 1, 0);
                    prev_stall = axi.WVALID && !axi.WREADY;
                    prev_pay = {axi.WDATA, axi.WSTRB, axi.WLAST};
                    if (axi.WVALID && axi.WREADY) begin
                        chk({name, "_beat"}, {27'd0, axi.WDATA, axi.WSTRB, axi.WLAST},
                            {27'd0, data0 + beats, exp_strb[beats*4 +: 4], (beats == n - 1)});
                        beats++;
                        if (axi.WLAST) wlast_seen = 1;
                    end
                end
                if (!wlast_seen) chk({name, "_wlast_timeout"}, 0, 1);
            end
            begin : b_side
                bit got_b;
                got_b = 0;
                for (int c = 0; c < 400 && !got_b; c++) begin
                    @(posedge ACLK); #1;
                    if (wlast_seen || early_b) begin
                        axi.BVALID = 1'b1; axi.BRESP = bresp;
                    end
                    @(negedge ACLK);
                    if (axi.BVALID && axi.BREADY) begin
                        got_b = 1;
                        chk({name, "_b_after_wlast"}, wlast_seen, 1);
                    end
                end
                if (!got_b) chk({name, "_b_timeout"}, 0, 1);
                @(posedge ACLK); #1;
                axi.BVALID = 1'b0;
            end
        join
        chk({name, "_beat_count"}, beats, n);
        @(negedge ACLK);
        chk({name, "_done"}, {done_valid, done_resp, cmd_ready}, {1'b1, bresp, 1'b0});
        @(negedge ACLK);
        chk({name, "_idle"}, {done_valid, cmd_ready}, 2'b01);
        $display("burst %s addr=%h len=%0d size=%0d burst=%0d beats=%0d resp=%0d",
                 name, addr, len, size, burst, beats, done_resp_seen(bresp));
    endtask

    function automatic int done_resp_seen(input logic [1:0] r);
        return int'(r);
    endfunction

    task automatic run_illegal(input string name, input logic [31:0] a, input logic [3:0] l,
                               input logic [2:0] s, input logic [1:0] b);
        send_cmd(name, a, l, s, b);
        @(negedge ACLK);
        chk({name, "_reject"}, {axi.AWVALID, done_valid, done_resp, cmd_ready}, {1'b0, 1'b1, 2'b10, 1'b0});
        @(negedge ACLK);
        chk({name, "_after"}, {axi.AWVALID, done_valid, cmd_ready}, 3'b001);
        $display("illegal %s addr=%h len=%0d size=%0d burst=%0d resp=2", name, a, l, s, b);
    endtask

    task automatic run_mid_reset();
        bit seen;
        seen = 0;
        send_cmd("rst", 32'h500, 4'd3, 3'd2, 2'b01);
        axi.AWREADY = 1'b1; axi.WREADY = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h5555_0000;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge ACLK);
            if (axi.WVALID) seen = 1;
        end
        chk("rst_reach_data", seen, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("rst_async", {cmd_ready, axi.AWVALID, axi.WVALID, axi.WLAST, axi.WSTRB, axi.BREADY, done_valid, wr_ready},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
        wr_valid = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rst_release", {cmd_ready, axi.AWVALID, axi.WVALID}, 3'b100);
        @(negedge ACLK);
        chk("rst_dropped", {axi.AWVALID, axi.WVALID, done_valid}, 3'b000);
        $display("reset mid-burst addr=00000500 dropped cmd_ready=%0d", cmd_ready);
    endtask

    initial begin
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;

        gen_check("gen_wrap38", 32'h38, 3'd2, 4'd3, 2'b10, 32'h3C, 4'hF);
        gen_check("gen_wrap3c", 32'h3C, 3'd2, 4'd3, 2'b10, 32'h30, 4'hF);
        gen_check("gen_wrap30", 32'h30, 3'd2, 4'd3, 2'b10, 32'h34, 4'hF);
        gen_check("gen_incr103", 32'h103, 3'd2, 4'd1, 2'b01, 32'h104, 4'b1000);
        gen_check("gen_narrow101", 32'h101, 3'd0, 4'd2, 2'b01, 32'h102, 4'b0010);
        gen_check("gen_fixed202", 32'h202, 3'd1, 4'd2, 2'b00, 32'h202, 4'b1100);

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_state", {cmd_ready, wr_ready, done_valid, done_resp, axi.AWVALID, axi.AWADDR,
                            axi.WVALID, axi.WLAST, axi.WSTRB, axi.BREADY},
            {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0});
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        run_burst("incr_basic",  32'h100, 4'd3, 3'd2, 2'b01, 32'hA0,   64'hFFFF, 2'b00, 0, -1, 16'h0, 1'b0);
        run_burst("incr_narrow", 32'h101, 4'd2, 3'd0, 2'b01, 32'h2000, 64'h0842, 2'b00, 0, -1, 16'h0, 1'b0);
        run_burst("wrap38",      32'h38,  4'd3, 3'd2, 2'b10, 32'h3000, 64'hFFFF, 2'b00, 2, -1, 16'h0, 1'b0);
        run_burst("fixed202",    32'h202, 4'd2, 3'd1, 2'b00, 32'h4000, 64'h0CCC, 2'b10, 0, -1, 16'h0, 1'b0);
        run_burst("stall_gap",   32'h400, 4'd3, 3'd2, 2'b01, 32'h5000, 64'hFFFF, 2'b01, 1, 1,  16'h5, 1'b1);

        run_illegal("wrap_len2",  32'h40,  4'd2, 3'd2, 2'b10);
        run_illegal("size3",      32'h80,  4'd0, 3'd3, 2'b01);
        run_illegal("burst_rsvd", 32'hC0,  4'd1, 3'd2, 2'b11);

        run_mid_reset();

        run_burst("incr_unalign", 32'h103, 4'd1, 3'd2, 2'b01, 32'h6000, 64'h00F8, 2'b00, 0, -1, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
